// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state, machine word, and the memory arbiter states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFETCH = 3'd1,
    DREAD  = 3'd2,
    DWRITE = 3'd3,
    RESP   = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter between instruction fetch and data load/store.
// Data wins by default; an aging counter forces a fetch after STARVE_MAX data grants.
//
//  state  | meaning
//  IDLE   | no access in flight; arbitration point
//  IFETCH | driving RAM read for fetch (drops back to IDLE if iREN goes away)
//  DREAD  | driving RAM read for a load
//  DWRITE | driving RAM write for a store
//  RESP   | one-cycle ack to the owner (iwait or dwait low)
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  ramstate_t         ramstate
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  arb_state_t        state, state_nx;
  logic              owner_i;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q;
  logic [CW-1:0]     starve_cnt;
  logic              grant_i, grant_r, grant_w;

  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_r  = 1'b0;
    grant_w  = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IDLE: begin
        if (iREN && (starve_cnt == CNT_MAX)) grant_i = 1'b1;
        else if (dWEN)                       grant_w = 1'b1;
        else if (dREN)                       grant_r = 1'b1;
        else if (iREN)                       grant_i = 1'b1;
        if (grant_i)      state_nx = IFETCH;
        else if (grant_w) state_nx = DWRITE;
        else if (grant_r) state_nx = DREAD;
      end
      IFETCH: begin
        // A flushed fetch releases the RAM immediately and never acks.
        if (!iREN) begin
          state_nx = IDLE;
        end else begin
          ramREN   = 1'b1;
          ramaddr  = addr_q;
          ramstore = store_q;
          if (ramstate == ACCESS) state_nx = RESP;
        end
      end
      DREAD: begin
        ramREN   = 1'b1;
        ramaddr  = addr_q;
        ramstore = store_q;
        if (ramstate == ACCESS) state_nx = RESP;
      end
      DWRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = addr_q;
        ramstore = store_q;
        if (ramstate == ACCESS) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      owner_i    <= 1'b0;
      addr_q     <= '0;
      store_q    <= '0;
      iload      <= '0;
      dload      <= '0;
      starve_cnt <= '0;
    end else begin
      state <= state_nx;
      if (grant_i) begin
        owner_i    <= 1'b1;
        addr_q     <= iaddr;
        starve_cnt <= '0;
      end
      if (grant_r || grant_w) begin
        owner_i <= 1'b0;
        addr_q  <= daddr;
        store_q <= dstore;
        if (iREN && (starve_cnt != CNT_MAX)) starve_cnt <= starve_cnt + 1'b1;
      end
      if ((state == IDLE) && !iREN) starve_cnt <= '0;
      if (ramstate == ACCESS) begin
        if ((state == IFETCH) && iREN) iload <= ramload;
        if (state == DREAD)            dload <= ramload;
      end
    end
  end

  assign iwait = !((state == RESP) && owner_i);
  assign dwait = !((state == RESP) && !owner_i);

  a_d_req_held: assert property (@(posedge CLK) disable iff (!nRST)
    ((state == DREAD) || (state == DWRITE)) |-> (dREN || dWEN));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters push expected grants/acks, a monitor pops and compares.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  word_t       iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  ramstate_t   ramstate = FREE;
  logic        iwait, dwait, ramREN, ramWEN;
  word_t       iload, dload, ramaddr, ramstore;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic  wr;
    word_t addr;
    word_t store;
  } grant_t;

  grant_t exp_g[$];
  word_t  exp_i[$];
  word_t  exp_d[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int ram_busy = 0, ram_err = 0;
  int ren_cycles = 0, str_cycles = 0, iack_cnt = 0, dack_cnt = 0;
  int iack_cyc = 0, dack_cyc = 0, first_strobe_cyc = 0;
  word_t last_i = '0, last_d = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic word_t ram_word(input word_t a);
    return a ^ 32'hDEADBEAF;
  endfunction

  task automatic chk(input string name, input word_t act, input word_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic exp_grant(input logic wr, input word_t a, input word_t s);
    grant_t g;
    g.wr = wr; g.addr = a; g.store = s;
    exp_g.push_back(g);
  endtask

  // RAM model: pattern of ERROR, then BUSY, then ACCESS, counted from the first strobed cycle.
  initial begin
    int rcnt;
    rcnt = 0;
    forever begin
      @(negedge CLK);
      if (ramREN || ramWEN) begin
        rcnt++;
        if (rcnt <= ram_err)                 ramstate = ERROR;
        else if (rcnt <= ram_err + ram_busy) ramstate = BUSY;
        else                                 ramstate = ACCESS;
        ramload = ram_word(ramaddr);
      end else begin
        rcnt = 0;
        ramstate = FREE;
        ramload = '0;
      end
    end
  end

  // Monitor: acks against per-requester queues, RAM grants against the expected grant order.
  initial begin
    logic   prev_strobe;
    grant_t cur;
    prev_strobe = 1'b0;
    cur.wr = 1'b0; cur.addr = '0; cur.store = '0;
    forever begin
      @(negedge CLK);
      chk("ack_exclusive", {31'b0, iwait | dwait}, 32'd1);
      if (!iwait) begin
        iack_cnt++; iack_cyc = cyc;
        if (exp_i.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_iack actual=iwait0 required=iwait1 cyc=%0d", cyc);
        end else chk("iload", iload, exp_i.pop_front());
      end
      if (!dwait) begin
        dack_cnt++; dack_cyc = cyc;
        if (exp_d.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_dack actual=dwait0 required=dwait1 cyc=%0d", cyc);
        end else chk("dload", dload, exp_d.pop_front());
      end
      if (ramREN || ramWEN) begin
        str_cycles++;
        if (ramREN) ren_cycles++;
        if (!prev_strobe) begin
          first_strobe_cyc = cyc;
          if (exp_g.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_grant actual=%h required=none", ramaddr);
          end else begin
            cur = exp_g.pop_front();
            chk("grant_wen", {31'b0, ramWEN}, {31'b0, cur.wr});
            chk("grant_ren", {31'b0, ramREN}, {31'b0, !cur.wr});
            chk("grant_addr", ramaddr, cur.addr);
            if (cur.wr) chk("grant_store", ramstore, cur.store);
          end
        end else begin
          chk("hold_addr", ramaddr, cur.addr);
        end
      end
      prev_strobe = ramREN || ramWEN;
    end
  end

  task automatic i_fetch(input word_t a);
    logic done;
    done = 1'b0;
    iaddr = a; iREN = 1'b1;
    last_i = ram_word(a);
    exp_i.push_back(last_i);
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge CLK);
      if (!iwait) done = 1'b1;
    end
    chk("i_ack_seen", {31'b0, done}, 32'd1);
    #1 iREN = 1'b0;
  endtask

  task automatic d_op(input logic wr, input word_t a, input word_t s);
    logic done;
    done = 1'b0;
    daddr = a; dstore = s; dWEN = wr; dREN = !wr;
    if (!wr) last_d = ram_word(a);
    exp_d.push_back(last_d);
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge CLK);
      if (!dwait) done = 1'b1;
    end
    chk("d_ack_seen", {31'b0, done}, 32'd1);
    #1 begin dREN = 1'b0; dWEN = 1'b0; end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_iwait"},    {31'b0, iwait},  32'd1);
    chk({tag, "_dwait"},    {31'b0, dwait},  32'd1);
    chk({tag, "_iload"},    iload,           32'd0);
    chk({tag, "_dload"},    dload,           32'd0);
    chk({tag, "_ramREN"},   {31'b0, ramREN}, 32'd0);
    chk({tag, "_ramWEN"},   {31'b0, ramWEN}, 32'd0);
    chk({tag, "_ramaddr"},  ramaddr,         32'd0);
    chk({tag, "_ramstore"}, ramstore,        32'd0);
  endtask

  initial begin
    int c0, c1, iack_before;
    logic done;

    // 1: reset for two cycles, then idle
    repeat (2) @(negedge CLK);
    check_reset("rst");
    #1 nRST = 1'b1;
    repeat (10) @(negedge CLK);
    check_reset("idle");
    #1;

    // 2: single fetch, two BUSY cycles before ACCESS
    ram_busy = 2; ram_err = 0;
    ren_cycles = 0; iack_cnt = 0; c0 = cyc;
    exp_grant(1'b0, 32'h40, '0);
    i_fetch(32'h40);
    chk("t2_ren_cycles", ren_cycles, 32'd3);
    chk("t2_strobe_start", first_strobe_cyc - c0, 32'd1);
    chk("t2_ack_cycle", iack_cyc - c0, 32'd4);
    chk("t2_iack_count", iack_cnt, 32'd1);
    chk("t2_iload_value", iload, 32'hDEADBEEF);
    repeat (2) @(negedge CLK); #1;

    // 3: store and fetch raised together; store first
    ram_busy = 0;
    exp_grant(1'b1, 32'h100, 32'h5);
    exp_grant(1'b0, 32'h44, '0);
    fork
      i_fetch(32'h44);
      d_op(1'b1, 32'h100, 32'h5);
    join
    chk("t3_d_before_i", {31'b0, dack_cyc < iack_cyc}, 32'd1);
    repeat (2) @(negedge CLK); #1;

    // 4: starvation bound of 2 with fetch held and loads back-to-back
    ram_busy = 1;
    exp_grant(1'b0, 32'h200, '0);
    exp_grant(1'b0, 32'h204, '0);
    exp_grant(1'b0, 32'h80,  '0);
    exp_grant(1'b0, 32'h208, '0);
    exp_grant(1'b0, 32'h20C, '0);
    exp_grant(1'b0, 32'h84,  '0);
    fork
      begin
        i_fetch(32'h80);
        i_fetch(32'h84);
      end
      begin
        d_op(1'b0, 32'h200, '0);
        d_op(1'b0, 32'h204, '0);
        d_op(1'b0, 32'h208, '0);
        d_op(1'b0, 32'h20C, '0);
      end
    join
    chk("t4_grants_consumed", exp_g.size(), 32'd0);
    repeat (2) @(negedge CLK); #1;

    // 5: fetch flushed mid-access, then a load is granted straight away
    ram_busy = 6;
    iack_before = iack_cnt;
    exp_grant(1'b0, 32'h90, '0);
    exp_grant(1'b0, 32'h300, '0);
    iaddr = 32'h90; iREN = 1'b1;
    repeat (3) @(negedge CLK);
    #1 iREN = 1'b0;
    c1 = cyc;
    ram_busy = 1;
    d_op(1'b0, 32'h300, '0);
    chk("t5_d_grant_latency", first_strobe_cyc - c1, 32'd2);
    chk("t5_no_iack", iack_cnt - iack_before, 32'd0);
    chk("t5_iload_held", iload, last_i);
    repeat (2) @(negedge CLK); #1;

    // 6a: three ERROR cycles then ACCESS during a load
    ram_err = 3; ram_busy = 0;
    str_cycles = 0; dack_cnt = 0; c0 = cyc;
    exp_grant(1'b0, 32'h400, '0);
    d_op(1'b0, 32'h400, '0);
    chk("t6_strobe_cycles", str_cycles, 32'd4);
    chk("t6_dack_count", dack_cnt, 32'd1);
    chk("t6_ack_cycle", dack_cyc - c0, 32'd5);
    repeat (2) @(negedge CLK); #1;

    // 6b: reset in the middle of a load
    ram_err = 0; ram_busy = 6;
    dack_cnt = 0;
    exp_grant(1'b0, 32'h500, '0);
    daddr = 32'h500; dREN = 1'b1;
    repeat (3) @(negedge CLK);
    chk("t6b_in_flight", {31'b0, ramREN}, 32'd1);
    #1 begin nRST = 1'b0; dREN = 1'b0; end
    @(negedge CLK);
    check_reset("midrst");
    #1 nRST = 1'b1;
    done = 1'b0;
    repeat (4) @(negedge CLK);
    chk("t6b_no_dack", dack_cnt, 32'd0);
    chk("t6b_ram_idle", {31'b0, ramREN | ramWEN}, 32'd0);

    chk("end_exp_g_empty", exp_g.size(), 32'd0);
    chk("end_exp_i_empty", exp_i.size(), 32'd0);
    chk("end_exp_d_empty", exp_d.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
